rpn_stack_alu: RTL and testbench
================================

// Module: rpn_stack_alu
// PURPOSE
//  Parametrised RPN calculator core; next generation of the single-width rpn unit.
//  Takes number-push and operator strobes from the UART command decoder and keeps
//  a DEPTH-entry operand stack. Returns a popped result with a 1-cycle ready pulse.
//  Adds DUP/SWAP/CLR, an iterative divider, and error reporting.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2); all arithmetic is unsigned, mod 2^WIDTH
//  DEPTH  8   stack entries (>=2); LVL_W = $clog2(DEPTH+1) is a localparam
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  op_en      in   1      1-cycle strobe: execute op
//  op         in   4      0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 POP, 5 DUP, 6 SWAP, 7 CLR, others illegal
//  num_en     in   1      1-cycle strobe: push num
//  num        in   WIDTH  operand to push
//  res_value  out  WIDTH  value of last POP, held until next POP
//  res_ready  out  1      1-cycle pulse when res_value updates
//  busy       out  1      divider running; strobes are rejected
//  err        out  1      1-cycle pulse on any rejected command
//  err_code   out  3      last error (held): 0 none, 1 OVF, 2 UNF, 3 DIVZ, 4 ILLEGAL, 5 BUSY
//  level      out  LVL_W  current stack occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (async, any state): stack empty, level=0, res_value=0, res_ready=0, busy=0,
//    err=0, err_code=0, FSM=IDLE. A division in progress is aborted.
//  - Notation: T = top of stack, N = entry below T. A binary op pops T and N and pushes N op T.
//  - FSM states: IDLE and DIV.
//    - IDLE -> DIV on an accepted DIV.
//    - DIV -> IDLE after exactly WIDTH iteration cycles.
//  - Strobes are sampled at the clock edge; effects are visible after that edge.
//  - Single-cycle commands (all except DIV) update level and stack on the sampling edge.
//  - num_en: push num. If level==DEPTH: OVF, push dropped, stack unchanged.
//  - ADD / SUB / MUL: result is the low WIDTH bits (SUB wraps; MUL keeps low half); level-1.
//  - POP: res_value<=T, level-1, res_ready=1 the cycle after the strobe.
//  - DUP: push T. SWAP: exchange T and N. CLR: level<=0; never errors.
//  - Precondition errors (stack unchanged, no res_ready):
//    - UNF: binary op or SWAP with level<2; POP or DUP with level==0.
//    - OVF: DUP with level==DEPTH.
//  - DIV (restoring, 1 bit/cycle):
//    - busy rises the cycle after the strobe and stays high exactly WIDTH cycles.
//    - Quotient N/T replaces N and T (level-1) on the edge where busy falls.
//    - T==0: DIVZ, no busy, stack unchanged. Remainder is discarded.
//  - Strobe while busy: dropped, BUSY error; no effect on the running division.
//  - op_en and num_en in the same cycle: neither executed, ILLEGAL error.
//  - Undefined op code: ILLEGAL error.
//  - Every error: err=1 for one cycle after the offending strobe; err_code updated and held.
//  - res_ready and err are never asserted by the same command.
// CONFIGURATION
//  RPN_DIV_EN defined: divider datapath and DIV state are built, as described above.
//  RPN_DIV_EN undefined: no divider logic; busy is tied to 0; op 3 gives ILLEGAL,
//    stack unchanged.
// TESTING (WIDTH=16, DEPTH=4 unless noted)
//  1. push 12, push 2, ADD, push 2, MUL, POP
//     -> res_value=28, res_ready pulses once, level=0, err never set.
//  2. push 2, push 5, SUB, POP -> res_value=16'hFFFD (wrap), no error.
//  3. push 1..4, push 5 -> err pulse, err_code=1, level=4;
//     then POP -> res_value=4.
//  4. RPN_DIV_EN: push 100, push 7, DIV
//     -> busy high exactly 16 cycles, then POP -> 14;
//     a push issued mid-busy -> err_code=5, level unaffected.
//  5. push 9, push 0, DIV -> err_code=3, busy stays 0, level=2;
//     POP on empty stack -> err_code=2, no res_ready.
//  6. op_en+num_en together -> err_code=4, level unchanged;
//     assert rst during DIV -> busy=0, level=0 immediately.

Source files
------------

// File: rtl/rpn_stack_alu.sv
// Purpose: DEPTH-entry RPN operand stack executing ADD/SUB/MUL/DIV/POP/DUP/SWAP/CLR on strobes.
// Latency: non-DIV commands act on the sampling edge; res_ready/err pulse the next cycle; DIV runs WIDTH busy cycles.
// Backpressure: none; any strobe while busy is dropped with a BUSY error. Divider built only when RPN_DIV_EN is defined.
module rpn_stack_alu #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_en,
  input  logic [3:0]                 op,
  input  logic                       num_en,
  input  logic [WIDTH-1:0]           num,
  output logic [WIDTH-1:0]           res_value,
  output logic                       res_ready,
  output logic                       busy,
  output logic                       err,
  output logic [2:0]                 err_code,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_POP  = 4'd4;
  localparam logic [3:0] OP_DUP  = 4'd5;
  localparam logic [3:0] OP_SWAP = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd7;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_OVF     = 3'd1;
  localparam logic [2:0] ERR_UNF     = 3'd2;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;
  localparam logic [2:0] ERR_BUSY    = 3'd5;
`ifdef RPN_DIV_EN
  localparam logic [2:0] ERR_DIVZ    = 3'd3;
`endif

  // Operand storage; validity of each entry is defined purely by level.
  logic [WIDTH-1:0] stk [DEPTH];

  logic [LVL_W-1:0] lvl_m1, lvl_m2;
  logic [IDX_W-1:0] t_idx, n_idx, p_idx;
  logic [WIDTH-1:0] t_val, n_val, alu_res;
  logic             full, has1, has2;

  logic             do_push, do_bin, do_pop, do_dup, do_swap, do_clr;
  logic             err_nxt;
  logic [2:0]       code_nxt;

  assign lvl_m1 = level - LVL_W'(1);
  assign lvl_m2 = level - LVL_W'(2);
  assign t_idx  = lvl_m1[IDX_W-1:0];
  assign n_idx  = lvl_m2[IDX_W-1:0];
  assign p_idx  = level[IDX_W-1:0];
  assign t_val  = stk[t_idx];
  assign n_val  = stk[n_idx];
  assign full   = (level == LVL_FULL);
  assign has1   = (level != '0);
  assign has2   = (level >= LVL_W'(2));

  // Single-cycle arithmetic: N op T, truncated to WIDTH bits.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = n_val + t_val;
      OP_SUB:  alu_res = n_val - t_val;
      OP_MUL:  alu_res = n_val * t_val;
      default: alu_res = '0;
    endcase
  end

`ifdef RPN_DIV_EN
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t           state_q, state_nxt;
  logic             do_div;
  logic [WIDTH-1:0] div_quo, div_rem, div_den, rem_nxt, div_result;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic [CNT_W-1:0] div_cnt;
  logic             div_ge, div_last, div_done;

  assign busy = (state_q == S_DIV);

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign rem_sh     = {div_rem, div_quo[WIDTH-1]};
  assign rem_sub    = rem_sh - {1'b0, div_den};
  assign div_ge     = ~rem_sub[WIDTH];
  assign rem_nxt    = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_last   = (div_cnt == CNT_W'(WIDTH-1));
  assign div_done   = busy && div_last;
  assign div_result = {div_quo[WIDTH-2:0], div_ge};

  // FSM state register; reset aborts any division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // FSM next state: enter DIV on an accepted divide, leave after WIDTH steps.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (do_div) state_nxt = S_DIV;
      S_DIV:   if (div_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider datapath: load N/T on acceptance, then shift one quotient bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_quo <= '0;
      div_rem <= '0;
      div_den <= '0;
      div_cnt <= '0;
    end else if (do_div) begin
      div_quo <= n_val;
      div_rem <= '0;
      div_den <= t_val;
      div_cnt <= '0;
    end else if (busy) begin
      div_quo <= div_result;
      div_rem <= rem_nxt;
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Command decode: pick the single action or error for this cycle's strobes.
  always_comb begin
    do_push  = 1'b0;
    do_bin   = 1'b0;
    do_pop   = 1'b0;
    do_dup   = 1'b0;
    do_swap  = 1'b0;
    do_clr   = 1'b0;
    err_nxt  = 1'b0;
    code_nxt = ERR_NONE;
`ifdef RPN_DIV_EN
    do_div   = 1'b0;
`endif
    if (op_en || num_en) begin
      if (busy) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_BUSY;
      end else if (op_en && num_en) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_ILLEGAL;
      end else if (num_en) begin
        if (full) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_OVF;
        end else begin
          do_push = 1'b1;
        end
      end else begin
        case (op)
          OP_ADD, OP_SUB, OP_MUL: begin
            if (has2) do_bin = 1'b1;
            else begin
              err_nxt  = 1'b1;
              code_nxt = ERR_UNF;
            end
          end
          OP_DIV: begin
`ifdef RPN_DIV_EN
            if (!has2) begin
              err_nxt  = 1'b1;
              code_nxt = ERR_UNF;
            end else if (t_val == '0) begin
              err_nxt  = 1'b1;
              code_nxt = ERR_DIVZ;
            end else begin
              do_div = 1'b1;
            end
`else
            err_nxt  = 1'b1;
            code_nxt = ERR_ILLEGAL;
`endif
          end
          OP_POP: begin
            if (has1) do_pop = 1'b1;
            else begin
              err_nxt  = 1'b1;
              code_nxt = ERR_UNF;
            end
          end
          OP_DUP: begin
            if (!has1) begin
              err_nxt  = 1'b1;
              code_nxt = ERR_UNF;
            end else if (full) begin
              err_nxt  = 1'b1;
              code_nxt = ERR_OVF;
            end else begin
              do_dup = 1'b1;
            end
          end
          OP_SWAP: begin
            if (has2) do_swap = 1'b1;
            else begin
              err_nxt  = 1'b1;
              code_nxt = ERR_UNF;
            end
          end
          OP_CLR:  do_clr = 1'b1;
          default: begin
            err_nxt  = 1'b1;
            code_nxt = ERR_ILLEGAL;
          end
        endcase
      end
    end
  end

  // Control state: occupancy, result register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= '0;
      res_value <= '0;
      res_ready <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      res_ready <= do_pop;
      err       <= err_nxt;
      if (err_nxt) err_code <= code_nxt;
      if (do_pop) res_value <= t_val;
      if (do_push || do_dup)        level <= level + LVL_W'(1);
      else if (do_bin || do_pop)    level <= lvl_m1;
      else if (do_clr)              level <= '0;
`ifdef RPN_DIV_EN
      else if (div_done)            level <= lvl_m1;
`endif
    end
  end

  // Stack storage writes; contents above level are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stk[p_idx] <= num;
    end else if (do_bin) begin
      stk[n_idx] <= alu_res;
    end else if (do_dup) begin
      stk[p_idx] <= t_val;
    end else if (do_swap) begin
      stk[t_idx] <= n_val;
      stk[n_idx] <= t_val;
    end
`ifdef RPN_DIV_EN
    else if (div_done) begin
      stk[n_idx] <= div_result;
    end
`endif
  end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Purpose: randomized and directed checks of rpn_stack_alu against a queue-based reference model.
// Latency: expected pulses are queued at issue time and popped by a negedge monitor.
// Backpressure: the driver waits out busy windows itself, injecting strobes only when testing rejection.
module tb_rpn_stack_alu;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_en = 1'b0;
  logic [3:0]   op = 4'd0;
  logic         num_en = 1'b0;
  logic [W-1:0] num = '0;
  logic [W-1:0] res_value;
  logic         res_ready, busy, err;
  logic [2:0]   err_code;
  logic [2:0]   level;

  rpn_stack_alu #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .op_en(op_en), .op(op), .num_en(num_en), .num(num),
    .res_value(res_value), .res_ready(res_ready), .busy(busy), .err(err),
    .err_code(err_code), .level(level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_err;
    int unsigned val;
  } ev_t;

  ev_t          exp_q[$];
  bit [W-1:0]   mstk[$];
  bit           m_busy = 1'b0;
  bit           m_div_go = 1'b0;
  bit           inject_busy = 1'b0;
  bit           no_wait = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void exp_err(input int unsigned code);
    ev_t e;
    e.is_err = 1'b1;
    e.val    = code;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_res(input int unsigned v);
    ev_t e;
    e.is_err = 1'b0;
    e.val    = v;
    exp_q.push_back(e);
  endfunction

  // Reference model: the stack is a queue whose back is the top of stack.
  function automatic void model(input bit oe, input bit [3:0] o, input bit ne, input bit [W-1:0] n);
    bit [W-1:0]      a, b;
    longint unsigned p;
    if (!oe && !ne) return;
    if (m_busy) begin exp_err(5); return; end
    if (oe && ne) begin exp_err(4); return; end
    if (ne) begin
      if (mstk.size() == D) exp_err(1);
      else mstk.push_back(n);
      return;
    end
    case (o)
      4'd0, 4'd1, 4'd2: begin
        if (mstk.size() < 2) exp_err(2);
        else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          if (o == 4'd0) p = longint'(a) + longint'(b);
          else if (o == 4'd1) p = longint'(a) + 65536 - longint'(b);
          else p = longint'(a) * longint'(b);
          mstk.push_back(W'(p % 65536));
        end
      end
      4'd3: begin
`ifdef RPN_DIV_EN
        if (mstk.size() < 2) exp_err(2);
        else if (mstk[$] == 0) exp_err(3);
        else begin
          m_busy   = 1'b1;
          m_div_go = 1'b1;
        end
`else
        exp_err(4);
`endif
      end
      4'd4: begin
        if (mstk.size() == 0) exp_err(2);
        else exp_res(mstk.pop_back());
      end
      4'd5: begin
        if (mstk.size() == 0) exp_err(2);
        else if (mstk.size() == D) exp_err(1);
        else mstk.push_back(mstk[$]);
      end
      4'd6: begin
        if (mstk.size() < 2) exp_err(2);
        else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          mstk.push_back(b);
          mstk.push_back(a);
        end
      end
      4'd7: mstk.delete();
      default: exp_err(4);
    endcase
  endfunction

  // Issue one strobe cycle; for an accepted divide, count busy cycles and then retire the quotient.
  task automatic do_cmd(input bit oe, input bit [3:0] o, input bit ne, input bit [W-1:0] n);
    int         cnt;
    bit [W-1:0] a, b;
    @(negedge clk);
    op_en  = oe;
    op     = o;
    num_en = ne;
    num    = n;
    model(oe, o, ne, n);
    @(posedge clk);
    #1;
    op_en  = 1'b0;
    num_en = 1'b0;
    if (m_div_go && !no_wait) begin
      m_div_go = 1'b0;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!busy) break;
        cnt++;
        if (inject_busy && cnt == 5) begin
          num_en = 1'b1;
          num    = W'($urandom);
          model(1'b0, 4'd0, 1'b1, num);
          @(posedge clk);
          #1;
          num_en = 1'b0;
        end
      end
      chk("div_busy_cycles", cnt, W);
      b = mstk.pop_back();
      a = mstk.pop_back();
      mstk.push_back(a / b);
      m_busy = 1'b0;
    end
    if (!no_wait) begin
      chk("level", level, mstk.size());
      chk("busy_idle", busy, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_value", res_value, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_pulses", {err, res_ready}, 0);
    mstk.delete();
    m_busy   = 1'b0;
    m_div_go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (res_ready || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {err, res_ready}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          chk("err_pulse_kind", {err, res_ready}, 2'b10);
          chk("err_code", err_code, e.val);
        end else begin
          chk("res_pulse_kind", {err, res_ready}, 2'b01);
          chk("res_value", res_value, e.val);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("init_level", level, 0);
    chk("init_busy", busy, 0);
    chk("init_res_value", res_value, 0);
    chk("init_err_code", err_code, 0);
    chk("init_pulses", {err, res_ready}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 12 2 + 2 * -> 28
    do_cmd(0, 0, 1, 16'd12);
    do_cmd(0, 0, 1, 16'd2);
    do_cmd(1, 4'd0, 0, 0);
    do_cmd(0, 0, 1, 16'd2);
    do_cmd(1, 4'd2, 0, 0);
    do_cmd(1, 4'd4, 0, 0);
    chk("t1_res", res_value, 28);
    chk("t1_level", level, 0);

    // 2 5 - wraps
    do_cmd(0, 0, 1, 16'd2);
    do_cmd(0, 0, 1, 16'd5);
    do_cmd(1, 4'd1, 0, 0);
    do_cmd(1, 4'd4, 0, 0);
    chk("t2_res", res_value, 16'hFFFD);

    // overflow on full stack
    for (int i = 1; i <= 5; i++) do_cmd(0, 0, 1, W'(i));
    chk("t3_err_code", err_code, 1);
    chk("t3_level", level, 4);
    do_cmd(1, 4'd4, 0, 0);
    chk("t3_res", res_value, 4);
    do_cmd(1, 4'd5, 0, 0);
    do_cmd(1, 4'd5, 0, 0);
    chk("t3_dup_ovf", err_code, 1);
    do_reset();

`ifdef RPN_DIV_EN
    // 100 / 7 with a rejected push while busy
    do_cmd(0, 0, 1, 16'd100);
    do_cmd(0, 0, 1, 16'd7);
    inject_busy = 1'b1;
    do_cmd(1, 4'd3, 0, 0);
    inject_busy = 1'b0;
    chk("t4_err_code", err_code, 5);
    chk("t4_level", level, 1);
    do_cmd(1, 4'd4, 0, 0);
    chk("t4_res", res_value, 14);
`endif

    // divide by zero (or illegal without divider), then empty-stack underflow
    do_cmd(0, 0, 1, 16'd9);
    do_cmd(0, 0, 1, 16'd0);
    do_cmd(1, 4'd3, 0, 0);
`ifdef RPN_DIV_EN
    chk("t5_err_code", err_code, 3);
`else
    chk("t5_err_code", err_code, 4);
`endif
    chk("t5_level", level, 2);
    do_cmd(1, 4'd6, 0, 0);
    do_cmd(1, 4'd7, 0, 0);
    do_cmd(1, 4'd4, 0, 0);
    chk("t5_unf", err_code, 2);
    do_cmd(0, 0, 1, 16'd33);
    chk("t5_code_held", err_code, 2);

    // simultaneous strobes and undefined op
    do_cmd(1, 4'd0, 1, 16'd44);
    chk("t6_err_code", err_code, 4);
    chk("t6_level", level, 1);
    do_cmd(0, 0, 1, 16'd1);
    do_cmd(1, 4'd12, 0, 0);
    chk("t6_badop", err_code, 4);

`ifdef RPN_DIV_EN
    // reset in the middle of a division
    do_cmd(1, 4'd7, 0, 0);
    do_cmd(0, 0, 1, 16'd500);
    do_cmd(0, 0, 1, 16'd3);
    no_wait = 1'b1;
    do_cmd(1, 4'd3, 0, 0);
    no_wait = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy_mid", busy, 1);
    do_reset();
`endif

    // randomized command stream
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)
        do_cmd(0, 0, 1, ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom));
      else if (r < 93)
        do_cmd(1, 4'($urandom_range(0, 7)), 0, 0);
      else if (r < 97)
        do_cmd(1, 4'($urandom_range(8, 15)), 0, 0);
      else
        do_cmd(1, 4'($urandom_range(0, 15)), 1, W'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
